instr_serializer: RTL and testbench

- Transmit-side counterpart of the instruction decoder.
- Accepts decoded instruction fields over a valid/ready handshake and packs them into the team's 16-bit instruction word.
- Shifts the word out serially, MSB first, with a frame strobe, so the remote SIPO/decoder end can rebuild and decode it.
- Sits between the test/control sequencer and the serial link to the FPGA-side SIPO.

---
 rtl/instr_pkg.sv | 31 +++
 rtl/instr_pack.sv | 33 +++
 rtl/instr_serializer.sv | 130 +++++++++++++
 tb/tb_instr_serializer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/instr_pkg.sv
// Shared instruction-word definitions: format selector values,
// field bit positions, ALU opcodes and the serializer state type.
package instr_pkg;

    localparam int INSTR_W = 16;

    localparam logic FMT_ALU = 1'b0;
    localparam logic FMT_JMP = 1'b1;

    localparam int KIND_BIT = 15;
    localparam int OPC_MSB  = 9;
    localparam int OPC_LSB  = 6;
    localparam int IN1_MSB  = 5;
    localparam int IN1_LSB  = 3;
    localparam int IN2_MSB  = 2;
    localparam int IN2_LSB  = 0;
    localparam int JZ_BIT   = 14;
    localparam int WR_BIT   = 13;
    localparam int ADDR_MSB = 7;
    localparam int ADDR_LSB = 0;

    localparam logic [3:0] OP_SHOW = 4'd5;
    localparam logic [3:0] OP_NOWR = 4'd6;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } ser_state_t;

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: field set in, 16-bit instruction word and
// illegal flag (jump_z together with mem_write) out.
module instr_pack
    import instr_pkg::*;
(
    input  logic               kind,
    input  logic [3:0]         aluop,
    input  logic [2:0]         in1,
    input  logic [2:0]         in2,
    input  logic [7:0]         data_addr,
    input  logic               jump_z,
    input  logic               mem_write,
    output logic [INSTR_W-1:0] word,
    output logic               illegal
);

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        if (kind == FMT_JMP) begin
            word[KIND_BIT]          = 1'b1;
            word[JZ_BIT]            = jump_z;
            word[WR_BIT]            = mem_write;
            word[ADDR_MSB:ADDR_LSB] = data_addr;
            illegal                 = jump_z & mem_write;
        end else begin
            word[OPC_MSB:OPC_LSB] = aluop;
            word[IN1_MSB:IN1_LSB] = in1;
            word[IN2_MSB:IN2_LSB] = in2;
        end
    end

endmodule

// File: rtl/instr_serializer.sv
// Packs a field set accepted over valid/ready and shifts the word out
// serially with a frame strobe, followed by GAP_CYCLES idle cycles.
// Ports: clk/rst, fmt_valid/fmt_ready handshake, field inputs,
// ser_out/ser_frame serial link, instr_word, enc_err pulse.
module instr_serializer
    import instr_pkg::*;
#(
    parameter int GAP_CYCLES = 1,
    parameter bit LSB_FIRST  = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fmt_valid,
    output logic               fmt_ready,
    input  logic               kind,
    input  logic [3:0]         aluop,
    input  logic [2:0]         in1,
    input  logic [2:0]         in2,
    input  logic [7:0]         data_addr,
    input  logic               jump_z,
    input  logic               mem_write,
    output logic               ser_out,
    output logic               ser_frame,
    output logic [INSTR_W-1:0] instr_word,
    output logic               enc_err
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    ser_state_t         state, state_n;
    logic [INSTR_W-1:0] sreg, sreg_n;
    logic [INSTR_W-1:0] word, iw_n;
    logic [3:0]         cnt, cnt_n;
    logic [GW-1:0]      gcnt, gcnt_n;
    logic               illegal;
    logic               rdy_n, so_n, sf_n, err_n;

    instr_pack u_pack (
        .kind      (kind),
        .aluop     (aluop),
        .in1       (in1),
        .in2       (in2),
        .data_addr (data_addr),
        .jump_z    (jump_z),
        .mem_write (mem_write),
        .word      (word),
        .illegal   (illegal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sreg       <= '0;
            cnt        <= '0;
            gcnt       <= '0;
            fmt_ready  <= 1'b1;
            ser_out    <= 1'b0;
            ser_frame  <= 1'b0;
            instr_word <= '0;
            enc_err    <= 1'b0;
        end else begin
            state      <= state_n;
            sreg       <= sreg_n;
            cnt        <= cnt_n;
            gcnt       <= gcnt_n;
            fmt_ready  <= rdy_n;
            ser_out    <= so_n;
            ser_frame  <= sf_n;
            instr_word <= iw_n;
            enc_err    <= err_n;
        end
    end

    // sreg always holds the bits not yet driven onto ser_out, with the
    // next one at the end selected by LSB_FIRST.
    always_comb begin
        state_n = state;
        sreg_n  = sreg;
        cnt_n   = cnt;
        gcnt_n  = gcnt;
        rdy_n   = fmt_ready;
        so_n    = 1'b0;
        sf_n    = ser_frame;
        iw_n    = instr_word;
        err_n   = 1'b0;
        unique case (state)
            IDLE: begin
                if (fmt_valid && fmt_ready) begin
                    if (illegal) begin
                        err_n = 1'b1;
                    end else begin
                        iw_n    = word;
                        so_n    = LSB_FIRST ? word[0] : word[INSTR_W-1];
                        sreg_n  = LSB_FIRST ? (word >> 1) : (word << 1);
                        sf_n    = 1'b1;
                        cnt_n   = '0;
                        rdy_n   = 1'b0;
                        state_n = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (cnt == 4'd15) begin
                    sf_n   = 1'b0;
                    gcnt_n = '0;
                    if (GAP_CYCLES > 0) begin
                        state_n = GAP;
                    end else begin
                        state_n = IDLE;
                        rdy_n   = 1'b1;
                    end
                end else begin
                    so_n   = LSB_FIRST ? sreg[0] : sreg[INSTR_W-1];
                    sreg_n = LSB_FIRST ? (sreg >> 1) : (sreg << 1);
                    cnt_n  = cnt + 4'd1;
                end
            end
            GAP: begin
                if (gcnt == GW'(GAP_CYCLES - 1)) begin
                    state_n = IDLE;
                    rdy_n   = 1'b1;
                end else begin
                    gcnt_n = gcnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_instr_serializer.sv
// Randomized and directed bench for instr_serializer with three
// instances: GAP_CYCLES=1 MSB-first, GAP_CYCLES=0, and LSB-first.
module tb_instr_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  vld;
    logic        kind;
    logic [3:0]  aluop;
    logic [2:0]  in1, in2;
    logic [7:0]  addr;
    logic        jz, wr;
    logic [2:0]  rdy, so, sf, err;
    logic [15:0] iw [3];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    instr_serializer #(.GAP_CYCLES(1), .LSB_FIRST(1'b0)) dut0 (
        .clk(clk), .rst(rst), .fmt_valid(vld[0]), .fmt_ready(rdy[0]),
        .kind(kind), .aluop(aluop), .in1(in1), .in2(in2),
        .data_addr(addr), .jump_z(jz), .mem_write(wr),
        .ser_out(so[0]), .ser_frame(sf[0]), .instr_word(iw[0]),
        .enc_err(err[0])
    );

    instr_serializer #(.GAP_CYCLES(0), .LSB_FIRST(1'b0)) dut1 (
        .clk(clk), .rst(rst), .fmt_valid(vld[1]), .fmt_ready(rdy[1]),
        .kind(kind), .aluop(aluop), .in1(in1), .in2(in2),
        .data_addr(addr), .jump_z(jz), .mem_write(wr),
        .ser_out(so[1]), .ser_frame(sf[1]), .instr_word(iw[1]),
        .enc_err(err[1])
    );

    instr_serializer #(.GAP_CYCLES(1), .LSB_FIRST(1'b1)) dut2 (
        .clk(clk), .rst(rst), .fmt_valid(vld[2]), .fmt_ready(rdy[2]),
        .kind(kind), .aluop(aluop), .in1(in1), .in2(in2),
        .data_addr(addr), .jump_z(jz), .mem_write(wr),
        .ser_out(so[2]), .ser_frame(sf[2]), .instr_word(iw[2]),
        .enc_err(err[2])
    );

    // Reference encoding straight from the word layout, by arithmetic.
    function automatic logic [15:0] enc(bit k, int op, int a, int b,
                                        int ad, bit j, bit w);
        if (k)
            return 16'(32768 + j * 16384 + w * 8192 + ad);
        return 16'(op * 64 + a * 8 + b);
    endfunction

    function automatic logic [15:0] cur_word();
        return enc(kind, int'(aluop), int'(in1), int'(in2),
                   int'(addr), jz, wr);
    endfunction

    task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        kind  = 1'($urandom);
        aluop = 4'($urandom);
        in1   = 3'($urandom);
        in2   = 3'($urandom);
        addr  = 8'($urandom);
        jz    = 1'($urandom);
        wr    = 1'($urandom);
    endtask

    task automatic wait_ready(int d);
        int n = 0;
        while (rdy[d] !== 1'b1 && n < 60) begin
            step();
            n++;
        end
        chk("ready_wait", 16'(rdy[d]), 16'd1);
    endtask

    // Sends the current field set on instance d and checks the frame.
    task automatic xfer(int d, int gap, bit lsb);
        logic [15:0] w;
        w = cur_word();
        wait_ready(d);
        vld[d] = 1'b1;
        step();
        vld[d] = 1'b0;
        scramble();
        for (int i = 0; i < 16; i++) begin
            chk("frame_hi", 16'(sf[d]), 16'd1);
            chk("bit", 16'(so[d]), 16'(lsb ? w[i] : w[15 - i]));
            chk("word", iw[d], w);
            chk("busy", 16'(rdy[d]), 16'd0);
            step();
        end
        chk("frame_end", 16'(sf[d]), 16'd0);
        chk("out_low", 16'(so[d]), 16'd0);
        for (int g = 0; g < gap; g++) begin
            chk("gap_busy", 16'(rdy[d]), 16'd0);
            step();
        end
        chk("ready_back", 16'(rdy[d]), 16'd1);
    endtask

    // fmt_valid held high: frames every 17+gap cycles, 16 of them high.
    task automatic stream(int d, int gap);
        int p;
        logic [15:0] w;
        p = 17 + gap;
        kind = 1'b1; jz = 1'b0; wr = 1'b1; addr = 8'h10;
        w = cur_word();
        wait_ready(d);
        vld[d] = 1'b1;
        step();
        for (int c = 0; c < 3 * p; c++) begin
            if ((c % p) < 16) begin
                chk("strm_frame", 16'(sf[d]), 16'd1);
                chk("strm_bit", 16'(so[d]), 16'(w[15 - (c % p)]));
                chk("strm_word", iw[d], w);
            end else begin
                chk("strm_gap", 16'(sf[d]), 16'd0);
                chk("strm_gap_out", 16'(so[d]), 16'd0);
            end
            step();
        end
        vld[d] = 1'b0;
        wait_ready(d);
    endtask

    initial begin
        logic [15:0] w;
        rst = 1'b1;
        vld = '0;
        kind = 0; aluop = 0; in1 = 0; in2 = 0;
        addr = 0; jz = 0; wr = 0;
        step();
        step();
        for (int d = 0; d < 3; d++) begin
            chk("rst_ready", 16'(rdy[d]), 16'd1);
            chk("rst_out", 16'(so[d]), 16'd0);
            chk("rst_frame", 16'(sf[d]), 16'd0);
            chk("rst_word", iw[d], 16'h0000);
            chk("rst_err", 16'(err[d]), 16'd0);
        end
        rst = 1'b0;
        step();

        kind = 1'b0; aluop = 4'd5; in1 = 3'd3; in2 = 3'd6;
        chk("model_015e", cur_word(), 16'h015E);
        xfer(0, 1, 1'b0);

        kind = 1'b1; jz = 1'b1; wr = 1'b0; addr = 8'hA5;
        chk("model_c0a5", cur_word(), 16'hC0A5);
        xfer(0, 1, 1'b0);

        kind = 1'b1; jz = 1'b1; wr = 1'b1; addr = 8'h33;
        vld[0] = 1'b1;
        step();
        vld[0] = 1'b0;
        chk("ill_err", 16'(err[0]), 16'd1);
        chk("ill_frame", 16'(sf[0]), 16'd0);
        chk("ill_word", iw[0], 16'hC0A5);
        chk("ill_ready", 16'(rdy[0]), 16'd1);
        step();
        chk("ill_err_gone", 16'(err[0]), 16'd0);
        chk("ill_frame2", 16'(sf[0]), 16'd0);

        stream(0, 1);
        stream(1, 0);

        kind = 1'b0; aluop = 4'd5; in1 = 3'd3; in2 = 3'd6;
        xfer(2, 1, 1'b1);

        kind = 1'b1; jz = 1'b0; wr = 1'b1; addr = 8'h5C;
        w = cur_word();
        wait_ready(0);
        vld[0] = 1'b1;
        step();
        vld[0] = 1'b0;
        repeat (7) step();
        chk("pre_rst_bit7", 16'(so[0]), 16'(w[8]));
        rst = 1'b1;
        vld[0] = 1'b1;
        step();
        rst = 1'b0;
        vld[0] = 1'b0;
        chk("abort_frame", 16'(sf[0]), 16'd0);
        chk("abort_out", 16'(so[0]), 16'd0);
        chk("abort_word", iw[0], 16'h0000);
        chk("abort_ready", 16'(rdy[0]), 16'd1);
        step();
        chk("abort_stays", 16'(sf[0]), 16'd0);
        kind = 1'b0; aluop = 4'd6; in1 = 3'd1; in2 = 3'd7;
        xfer(0, 1, 1'b0);

        for (int r = 0; r < 12; r++) begin
            scramble();
            if (kind && jz && wr) wr = 1'b0;
            xfer(r % 3, (r % 3 == 1) ? 0 : 1, r % 3 == 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
